// File: rtl/switch_input_reader_pkg.sv
// ============================================================================
// Module   : switch_input_reader_pkg
// Brief    : Shared types and default widths for the switch input reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_input_reader_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2,
      DONE         = 2'd3
   } state_t;

   localparam logic ENTER_PRESSED       = 1'b0;
   localparam int   DEF_DATA_W          = 15;
   localparam int   DEF_DOUT_W          = 32;
   localparam int   DEF_DEBOUNCE_CYCLES = 4;
   localparam int   DEF_CNT_W           = 3;

endpackage

`default_nettype wire

// File: rtl/switch_input_reader_button_debouncer.sv
// ============================================================================
// Module   : button_debouncer
// Brief    : Two-flop synchronizer plus stability counter; emits registered
//            one-cycle press/release pulses on debounced level changes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer
   import switch_input_reader_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int   CNT_W           = DEF_CNT_W,
   parameter logic PRESSED_LEVEL   = ENTER_PRESSED
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_i,
   output logic press_o,
   output logic release_o
);

   localparam logic             RELEASED_LEVEL = ~PRESSED_LEVEL;
   localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             release_q, release_d;

   // Any cycle of agreement restarts the stability window.
   always_comb begin
      level_d   = level_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d   = sync2_q;
            press_d   = (sync2_q == PRESSED_LEVEL);
            release_d = (sync2_q != PRESSED_LEVEL);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q   <= RELEASED_LEVEL;
         sync2_q   <= RELEASED_LEVEL;
         level_q   <= RELEASED_LEVEL;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

`default_nettype wire

// File: rtl/switch_input_reader.sv
// ============================================================================
// Module   : switch_input_reader
// Brief    : Waits for an operator press/release of enter, then returns the
//            captured switch value with a one-cycle in_valid pulse.
//            Build option: INPUT_SIGN_EXT_EN sign-extends in_data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_input_reader
   import switch_input_reader_pkg::*;
#(
   parameter int DATA_W          = DEF_DATA_W,
   parameter int DOUT_W          = DEF_DOUT_W,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enter,
   input  logic [DATA_W-1:0] switches,
   input  logic              in_req,
   output logic              in_valid,
   output logic [DOUT_W-1:0] in_data,
   output logic              LED
);

   localparam int FILL_W = DOUT_W - DATA_W;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] capture_q, capture_d;
   logic [DOUT_W-1:0] in_data_q, in_data_d;
   logic [DOUT_W-1:0] ext_data;
   logic              press_edge, release_edge;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .PRESSED_LEVEL   (ENTER_PRESSED)
   ) u_enter_db (
      .clock     (clock),
      .reset     (reset),
      .btn_i     (enter),
      .press_o   (press_edge),
      .release_o (release_edge)
   );

`ifdef INPUT_SIGN_EXT_EN
   assign ext_data = {{FILL_W{capture_q[DATA_W-1]}}, capture_q};
`else
   assign ext_data = {{FILL_W{1'b0}}, capture_q};
`endif

   // in_data is loaded on entry to DONE so an abort leaves the old value intact.
   always_comb begin
      state_d   = state_q;
      capture_d = capture_q;
      in_data_d = in_data_q;
      case (state_q)
         IDLE: begin
            if (in_req) state_d = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            if (!in_req) begin
               state_d = IDLE;
            end else if (press_edge) begin
               capture_d = switches;
               state_d   = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (!in_req) begin
               state_d = IDLE;
            end else if (release_edge) begin
               in_data_d = ext_data;
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         capture_q <= '0;
         in_data_q <= '0;
      end else begin
         state_q   <= state_d;
         capture_q <= capture_d;
         in_data_q <= in_data_d;
      end
   end

   assign in_valid = (state_q == DONE);
   assign in_data  = in_data_q;
   assign LED      = (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);

endmodule

`default_nettype wire

// File: tb/tb_switch_input_reader.sv
// ============================================================================
// Module   : tb_switch_input_reader
// Brief    : Directed table-driven bench for switch_input_reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_input_reader;

   logic        clock;
   logic        reset;
   logic        enter;
   logic [14:0] switches;
   logic        in_req;
   logic        in_valid;
   logic [31:0] in_data;
   logic        LED;

   int n_vec;
   int n_err;
   int pulses;

   typedef struct {
      string       name;
      logic [14:0] sw_press;
      logic [14:0] sw_release;
      logic [31:0] exp;
      int          low;
   } vec_t;

   vec_t vecs[5];

`ifdef INPUT_SIGN_EXT_EN
   localparam logic [31:0] EXP_7FFF = 32'hFFFF_FFFF;
   localparam logic [31:0] EXP_4001 = 32'hFFFF_C001;
`else
   localparam logic [31:0] EXP_7FFF = 32'h0000_7FFF;
   localparam logic [31:0] EXP_4001 = 32'h0000_4001;
`endif

   switch_input_reader dut (
      .clock    (clock),
      .reset    (reset),
      .enter    (enter),
      .switches (switches),
      .in_req   (in_req),
      .in_valid (in_valid),
      .in_data  (in_data),
      .LED      (LED)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (in_valid) pulses++;
   endtask

   // Full press/release handshake; entered with the FSM in IDLE or WAIT_PRESS.
   task automatic do_txn(input vec_t v);
      bit got;
      bit led_ok;
      pulses   = 0;
      switches = v.sw_press;
      in_req   = 1'b1;
      step();
      check({v.name, "_led_wait"}, 32'(LED), 32'd1);
      enter = 1'b0;
      repeat (v.low) step();
      enter = 1'b1;
      repeat (4) step();
      switches = v.sw_release;
      got    = 1'b0;
      led_ok = 1'b1;
      for (int i = 0; i < 30 && !got; i++) begin
         step();
         if (in_valid) got = 1'b1;
         else if (LED !== 1'b1) led_ok = 1'b0;
      end
      check({v.name, "_led_held"}, 32'(led_ok), 32'd1);
      check({v.name, "_valid_seen"}, 32'(got), 32'd1);
      check({v.name, "_data"}, in_data, v.exp);
      check({v.name, "_led_done"}, 32'(LED), 32'd0);
      in_req = 1'b0;
      step();
      check({v.name, "_valid_1cyc"}, 32'(in_valid), 32'd0);
      repeat (3) step();
      check({v.name, "_pulse_count"}, 32'(pulses), 32'd1);
      check({v.name, "_data_hold"}, in_data, v.exp);
   endtask

   initial begin
      vec_t hk;
      n_vec    = 0;
      n_err    = 0;
      pulses   = 0;
      reset    = 1'b1;
      enter    = 1'b1;
      switches = '0;
      in_req   = 1'b0;

      vecs[0] = '{"basic",    15'h0123, 15'h0123, 32'h0000_0123, 10};
      vecs[1] = '{"min_hold", 15'h0005, 15'h7FFF, 32'h0000_0005, 4};
      vecs[2] = '{"zero",     15'h0000, 15'h7FFF, 32'h0000_0000, 10};
      vecs[3] = '{"all_ones", 15'h7FFF, 15'h0000, EXP_7FFF,      10};
      vecs[4] = '{"msb_set",  15'h4001, 15'h0001, EXP_4001,      10};

      #1;
      check("rst_valid", 32'(in_valid), 32'd0);
      check("rst_data",  in_data,       32'd0);
      check("rst_led",   32'(LED),      32'd0);
      repeat (2) step();
      reset = 1'b0;
      repeat (2) step();
      check("idle_led", 32'(LED), 32'd0);

      // Bounce: short pulses and a run one cycle too short must not press.
      in_req = 1'b1;
      pulses = 0;
      step();
      enter = 1'b0; step();
      enter = 1'b1; step();
      enter = 1'b0; step();
      enter = 1'b1;
      repeat (10) step();
      check("bounce_led", 32'(LED), 32'd1);
      enter = 1'b0;
      repeat (3) step();
      enter = 1'b1;
      repeat (12) step();
      check("short_led", 32'(LED), 32'd1);
      check("short_pulses", 32'(pulses), 32'd0);
      in_req = 1'b0;
      step();
      check("bounce_abort_led", 32'(LED), 32'd0);

      for (int i = 0; i < 5; i++) do_txn(vecs[i]);

      // Held key: a press debounced before the request is not a capture.
      pulses = 0;
      enter  = 1'b0;
      repeat (10) step();
      check("held_idle_led", 32'(LED), 32'd0);
      switches = 15'h0777;
      in_req   = 1'b1;
      repeat (10) step();
      check("held_led", 32'(LED), 32'd1);
      enter = 1'b1;
      repeat (10) step();
      check("held_rel_led", 32'(LED), 32'd1);
      check("held_pulses", 32'(pulses), 32'd0);
      hk = '{"held", 15'h0042, 15'h7000, 32'h0000_0042, 10};
      do_txn(hk);

      // Abort in WAIT_RELEASE keeps the previous in_data.
      pulses   = 0;
      switches = 15'h1111;
      in_req   = 1'b1;
      step();
      enter = 1'b0;
      repeat (10) step();
      check("abort_pre_led", 32'(LED), 32'd1);
      in_req = 1'b0;
      step();
      check("abort_led", 32'(LED), 32'd0);
      enter = 1'b1;
      repeat (12) step();
      check("abort_pulses", 32'(pulses), 32'd0);
      check("abort_data", in_data, 32'h0000_0042);

      // Reset mid-WAIT_PRESS returns asynchronously to reset values.
      pulses = 0;
      in_req = 1'b1;
      step();
      check("mid_led", 32'(LED), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_led",  32'(LED),  32'd0);
      check("mid_rst_data", in_data,   32'd0);
      check("mid_rst_valid", 32'(in_valid), 32'd0);
      repeat (2) step();
      reset  = 1'b0;
      in_req = 1'b0;
      repeat (8) step();
      check("mid_rst_pulses", 32'(pulses), 32'd0);
      check("mid_rst_data_after", in_data, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
